// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM playback controller.
package pdm_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned VOL_W    = 4;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, FINISH} state_e;

   // Sign-preserving volume attenuation.
   function automatic logic [SAMPLE_W-1:0] attenuate(input logic [SAMPLE_W-1:0] sample,
                                                     input logic [VOL_W-1:0]    shift);
      logic signed [SAMPLE_W-1:0] s;
      s = sample;
      return s >>> shift;
   endfunction

endpackage

// File: rtl/pdm_playback_ctrl_if.sv
// Sample-memory fetch handshake between the playback controller and the sample store.
interface pdm_playback_ctrl_if #(
   parameter int unsigned ADDR_W = 16
);
   import pdm_pkg::*;

   logic                mem_req_out;
   logic [ADDR_W-1:0]   mem_addr_out;
   logic                mem_valid_in;
   logic [SAMPLE_W-1:0] mem_data_in;

   modport master (
      output mem_req_out,
      output mem_addr_out,
      input  mem_valid_in,
      input  mem_data_in
   );

   modport slave (
      input  mem_req_out,
      input  mem_addr_out,
      output mem_valid_in,
      output mem_data_in
   );

endinterface

// File: rtl/pdm_tick_gen.sv
// Free-running PDM tick strobe and audio sample-rate strobe.
module pdm_tick_gen #(
   parameter int unsigned TICK_DIV = 4,
   parameter int unsigned OSR      = 64
) (
   input  logic clk_in,
   input  logic rst_n_in,
   output logic tick_out,
   output logic strobe_out
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned OW = $clog2(OSR);

   logic [TW-1:0] tick_cnt_q;
   logic [OW-1:0] osr_cnt_q;

   assign tick_out   = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign strobe_out = tick_out && (osr_cnt_q == OW'(OSR - 1));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tick_cnt_q <= '0;
         osr_cnt_q  <= '0;
      end else begin
         tick_cnt_q <= tick_out ? '0 : tick_cnt_q + TW'(1);
         if (strobe_out) begin
            osr_cnt_q <= '0;
         end else if (tick_out) begin
            osr_cnt_q <= osr_cnt_q + OW'(1);
         end
      end
   end

endmodule

// File: rtl/pdm_playback_ctrl.sv
// Playback sequencer: fetches samples with one-deep prefetch and feeds the PDM level input
// at the audio sample rate.
module pdm_playback_ctrl
   import pdm_pkg::*;
#(
   parameter int unsigned TICK_DIV = 4,
   parameter int unsigned OSR      = 64,
   parameter int unsigned ADDR_W   = 16
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                start_in,
   input  logic                stop_in,
   input  logic [ADDR_W-1:0]   base_addr_in,
   input  logic [ADDR_W-1:0]   length_in,
   input  logic                loop_in,
   input  logic [VOL_W-1:0]    volume_in,
   pdm_playback_ctrl_if.master mem,
   output logic                tick_out,
   output logic [SAMPLE_W-1:0] level_out,
   output logic                busy_out,
   output logic                done_out,
   output logic                underrun_out
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   remaining_q, remaining_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   length_q, length_d;
   logic [SAMPLE_W-1:0] staging_q, staging_d;
   logic                staged_q, staged_d;
   logic [SAMPLE_W-1:0] level_q, level_d;
   logic                done_q, done_d;
   logic                underrun_q, underrun_d;
   logic                strobe;

   pdm_tick_gen #(
      .TICK_DIV (TICK_DIV),
      .OSR      (OSR)
   ) u_tick_gen (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .tick_out   (tick_out),
      .strobe_out (strobe)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      base_d      = base_q;
      length_d    = length_q;
      staging_d   = staging_q;
      staged_d    = staged_q;
      level_d     = level_q;
      done_d      = 1'b0;
      underrun_d  = 1'b0;

      if (state_q != IDLE && stop_in) begin
         // Abort drops any fetch data arriving this cycle.
         state_d  = IDLE;
         staged_d = 1'b0;
         level_d  = '0;
         done_d   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_in && !stop_in) begin
                  base_d   = base_addr_in;
                  length_d = length_in;
                  if (length_in == '0) begin
                     done_d = 1'b1;
                  end else begin
                     addr_d      = base_addr_in;
                     remaining_d = length_in;
                     state_d     = FETCH;
                  end
               end
            end
            FETCH: begin
               // A late sample is still captured but only plays at the next strobe.
               underrun_d = strobe && !staged_q;
               if (mem.mem_valid_in) begin
                  staging_d   = mem.mem_data_in;
                  staged_d    = 1'b1;
                  addr_d      = addr_q + ADDR_W'(1);
                  remaining_d = remaining_q - ADDR_W'(1);
                  state_d     = HOLD;
               end
            end
            HOLD: begin
               if (strobe) begin
                  level_d  = attenuate(staging_q, volume_in);
                  staged_d = 1'b0;
                  if (remaining_q != '0) begin
                     state_d = FETCH;
                  end else if (loop_in) begin
                     addr_d      = base_q;
                     remaining_d = length_q;
                     state_d     = FETCH;
                  end else begin
                     state_d = FINISH;
                  end
               end
            end
            FINISH: begin
               if (strobe) begin
                  level_d = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         base_q      <= '0;
         length_q    <= '0;
         staging_q   <= '0;
         staged_q    <= 1'b0;
         level_q     <= '0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         base_q      <= base_d;
         length_q    <= length_d;
         staging_q   <= staging_d;
         staged_q    <= staged_d;
         level_q     <= level_d;
         done_q      <= done_d;
         underrun_q  <= underrun_d;
      end
   end

   assign mem.mem_req_out  = (state_q == FETCH);
   assign mem.mem_addr_out = addr_q;
   assign level_out        = level_q;
   assign busy_out         = (state_q != IDLE);
   assign done_out         = done_q;
   assign underrun_out     = underrun_q;

endmodule

// File: tb/tb_pdm_playback_ctrl.sv
// Directed bench for pdm_playback_ctrl with TICK_DIV=4, OSR=4 (sample strobe every 16 clocks).
module tb_pdm_playback_ctrl;
   import pdm_pkg::*;

   typedef struct packed {
      logic [15:0] level;
      logic        done;
      logic        underrun;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [15:0] base = '0;
   logic [15:0] length = '0;
   logic [3:0]  volume = '0;
   logic        tick, busy, done, underrun;
   logic [15:0] level;

   int total = 0;
   int bad = 0;
   int k;
   int mem_delay = 0;
   int mem_cnt = 0;
   int k0;
   logic [15:0] img [0:15];
   exp_t        lvl_q[$];
   logic [15:0] addr_q[$];

   pdm_playback_ctrl_if #(.ADDR_W(16)) bus ();

   pdm_playback_ctrl #(
      .TICK_DIV (4),
      .OSR      (4),
      .ADDR_W   (16)
   ) dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .start_in     (start),
      .stop_in      (stop),
      .base_addr_in (base),
      .length_in    (length),
      .loop_in      (loop_en),
      .volume_in    (volume),
      .mem          (bus),
      .tick_out     (tick),
      .level_out    (level),
      .busy_out     (busy),
      .done_out     (done),
      .underrun_out (underrun)
   );

   always #5 clk = ~clk;

   // Posedges since reset release; the DUT tick counter equals k % 4.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [15:0] lvl, input logic d, input logic u);
      exp_t e;
      e.level = lvl;
      e.done = d;
      e.underrun = u;
      lvl_q.push_back(e);
   endtask

   task automatic wait_k(input int t);
      while (k < t) @(negedge clk);
   endtask

   // Sample memory: responds after mem_delay requesting cycles, checks the fetch address.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_valid_in = 1'b0;
         bus.mem_data_in  = '0;
         mem_cnt = 0;
      end else if (bus.mem_req_out) begin
         if (mem_cnt >= mem_delay) begin
            bus.mem_valid_in = 1'b1;
            bus.mem_data_in  = img[bus.mem_addr_out[3:0]];
            check("fetch_expected", 32'(addr_q.size() > 0), 32'd1);
            if (addr_q.size() > 0) check("fetch_addr", bus.mem_addr_out, addr_q.pop_front());
         end else begin
            bus.mem_valid_in = 1'b0;
         end
         mem_cnt++;
      end else begin
         bus.mem_valid_in = 1'b0;
         mem_cnt = 0;
      end
   end

   // Tick cadence every cycle; scoreboard pop on the cycle after each sample strobe.
   always @(negedge clk) begin
      if (rst_n) begin
         check("tick", 32'(tick), 32'(k % 4 == 3));
         if (k > 0 && k % 16 == 0 && lvl_q.size() > 0) begin
            exp_t e;
            e = lvl_q.pop_front();
            check("strobe_level", level, e.level);
            check("strobe_done", done, e.done);
            check("strobe_underrun", underrun, e.underrun);
         end
      end
   end

   task automatic end_of_run();
      check("lvl_q_empty", lvl_q.size(), 0);
      check("addr_q_empty", addr_q.size(), 0);
      check("idle_busy", busy, 0);
      check("idle_level", level, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_level", level, 0);
      check("rst_busy", busy, 0);
      check("rst_req", bus.mem_req_out, 0);
      check("rst_done", done, 0);
      check("rst_underrun", underrun, 0);
      check("rst_tick", tick, 0);
      rst_n = 1'b1;

      // Basic playback, volume 0.
      wait_k(16);
      k0 = k;
      img[0] = 16'h1000; img[1] = 16'h2000; img[2] = 16'h7FFF;
      base = 16'h0010; length = 16'd3; volume = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      addr_q.push_back(16'h0010); addr_q.push_back(16'h0011); addr_q.push_back(16'h0012);
      push_exp(16'h1000, 0, 0); push_exp(16'h2000, 0, 0); push_exp(16'h7FFF, 0, 0);
      push_exp(16'h0000, 1, 0);
      check("run1_busy", busy, 1);
      check("run1_req", bus.mem_req_out, 1);
      wait_k(k0 + 65);
      end_of_run();

      // Volume 2 on negative and positive extremes; a start while busy is ignored.
      wait_k(80);
      k0 = k;
      img[0] = 16'h8000; img[1] = 16'h7FFF; img[2] = 16'h1000;
      base = 16'h0010; length = 16'd3; volume = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      addr_q.push_back(16'h0010); addr_q.push_back(16'h0011); addr_q.push_back(16'h0012);
      push_exp(16'hE000, 0, 0); push_exp(16'h1FFF, 0, 0); push_exp(16'h0400, 0, 0);
      push_exp(16'h0000, 1, 0);
      wait_k(k0 + 5);
      base = 16'h0030; length = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_start_done", done, 0);
      check("busy_start_busy", busy, 1);
      wait_k(k0 + 65);
      end_of_run();

      // Second fetch arrives 20 clocks late: underrun, level holds, late sample plays next.
      wait_k(144);
      k0 = k;
      img[0] = 16'h1234; img[1] = 16'h4321;
      base = 16'h0030; length = 16'd2; volume = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      addr_q.push_back(16'h0030); addr_q.push_back(16'h0031);
      push_exp(16'h1234, 0, 0); push_exp(16'h1234, 0, 1); push_exp(16'h4321, 0, 0);
      push_exp(16'h0000, 1, 0);
      wait_k(k0 + 8);
      mem_delay = 20;
      wait_k(k0 + 40);
      mem_delay = 0;
      wait_k(k0 + 65);
      end_of_run();

      // Looping across the address wrap, then abort while a fetch is pending.
      wait_k(224);
      k0 = k;
      img[15] = 16'h0F0F; img[0] = 16'h3C3C;
      base = 16'hFFFF; length = 16'd2; volume = 4'd1; loop_en = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      addr_q.push_back(16'hFFFF); addr_q.push_back(16'h0000);
      addr_q.push_back(16'hFFFF); addr_q.push_back(16'h0000);
      push_exp(16'h0787, 0, 0); push_exp(16'h1E1E, 0, 0);
      push_exp(16'h0787, 0, 0); push_exp(16'h1E1E, 0, 0);
      wait_k(k0 + 50);
      mem_delay = 50;
      wait_k(k0 + 70);
      check("loop_req_pending", bus.mem_req_out, 1);
      check("loop_addr_wrapped", bus.mem_addr_out, 16'hFFFF);
      check("loop_busy", busy, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_req", bus.mem_req_out, 0);
      check("stop_level", level, 0);
      check("stop_done", done, 1);
      check("stop_busy", busy, 0);
      @(negedge clk);
      check("stop_done_pulse", done, 0);
      mem_delay = 0;
      loop_en = 1'b0;
      end_of_run();

      // Zero-length start.
      wait_k(320);
      base = 16'h0050; length = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      check("len0_req", bus.mem_req_out, 0);
      @(negedge clk);
      check("len0_done_pulse", done, 0);

      // Simultaneous start and stop: nothing happens.
      base = 16'h0010; length = 16'd3; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check("ss_busy", busy, 0);
      check("ss_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         check("ss_req", bus.mem_req_out, 0);
         @(negedge clk);
      end

      // Asynchronous reset in HOLD.
      wait_k(352);
      k0 = k;
      img[0] = 16'h1000; img[1] = 16'h2000; img[2] = 16'h7FFF;
      base = 16'h0010; length = 16'd3; volume = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      addr_q.push_back(16'h0010); addr_q.push_back(16'h0011);
      push_exp(16'h1000, 0, 0);
      wait_k(k0 + 20);
      check("hold_level", level, 16'h1000);
      check("hold_busy", busy, 1);
      check("hold_req", bus.mem_req_out, 0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_level", level, 0);
      check("arst_busy", busy, 0);
      check("arst_req", bus.mem_req_out, 0);
      check("arst_done", done, 0);
      check("arst_underrun", underrun, 0);
      check("arst_tick", tick, 0);
      check("arst_lvl_q", lvl_q.size(), 0);
      check("arst_addr_q", addr_q.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_level", level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
